// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU for the CPU datapath.
// Logic, shift, rotate, add, sub, neg and not complete in a single cycle.
// Signed multiply (radix-2 Booth) and signed divide (restoring division on
// magnitudes) iterate one bit per cycle and return a 2*WIDTH result on hi/lo.
// A start/busy/done handshake lets the control unit stall while an iterative
// operation is in flight.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             carry,
  output logic             div0,
  output logic             illegal
);

  localparam int SH = $clog2(WIDTH);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Everything that is published at completion, held until the next one.
  typedef struct packed {
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             z;
    logic             c;
    logic             d0;
    logic             ill;
  } res_t;

  state_t state, state_nx;
  res_t   res, r1, rf;

  // Iterative datapath. For mul: acc:mq:q1 is the Booth shift register and
  // m the multiplicand. For div: acc holds the partial remainder, mq the
  // dividend bits shifting out / quotient bits shifting in, m the divisor
  // magnitude.
  logic [WIDTH:0]   acc, acc_nx;
  logic [WIDTH-1:0] mq, mq_nx;
  logic             q1, q1_nx;
  logic [WIDTH-1:0] m;
  logic [SH-1:0]    cnt;
  logic             fin;
  logic             op_mul;
  logic             neg_q, neg_r;

  logic             accept, is_mul, is_div, b_zero, iter_op;
  logic [SH-1:0]    amt;
  logic [WIDTH:0]   addw, subw;
  logic [WIDTH-1:0] rotr, rotl;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   booth, dsh, ddiff;

  assign accept  = start && (state != RUN);
  assign is_mul  = (opcode == OP_MUL);
  assign is_div  = (opcode == OP_DIV);
  assign b_zero  = (B == '0);
  // div by zero completes in one cycle like the plain ALU ops
  assign iter_op = is_mul || (is_div && !b_zero);
  assign amt     = B[SH-1:0];
  assign a_mag   = A[WIDTH-1] ? ('0 - A) : A;
  assign b_mag   = B[WIDTH-1] ? ('0 - B) : B;

  // Single-cycle results, computed straight from the inputs at acceptance.
  always_comb begin
    r1   = '0;
    addw = {1'b0, A} + {1'b0, B};
    subw = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
    rotr = WIDTH'({A, A} >> amt);
    rotl = WIDTH'(({A, A} << amt) >> WIDTH);
    case (opcode)
      OP_ADD:  begin r1.lo = addw[WIDTH-1:0]; r1.c = addw[WIDTH]; end
      OP_SUB:  begin r1.lo = subw[WIDTH-1:0]; r1.c = subw[WIDTH]; end
      OP_AND:  r1.lo = A & B;
      OP_OR:   r1.lo = A | B;
      OP_SHR:  r1.lo = A >> amt;
      OP_SHRA: r1.lo = $signed(A) >>> amt;
      OP_SHL:  r1.lo = A << amt;
      OP_ROR:  r1.lo = rotr;
      OP_ROL:  r1.lo = rotl;
      OP_NEG:  r1.lo = '0 - A;
      OP_NOT:  r1.lo = ~A;
      OP_MUL:  r1.ill = 1'b0;
      // only consulted when B == 0; nonzero divisors take the RUN path
      OP_DIV:  begin r1.lo = '1; r1.hi = A; r1.d0 = 1'b1; end
      default: r1.ill = 1'b1;
    endcase
    r1.z = (r1.lo == '0);
  end

  // One Booth step or one restoring-division step per cycle.
  always_comb begin
    booth = acc;
    case ({mq[0], q1})
      2'b01:   booth = acc + {m[WIDTH-1], m};
      2'b10:   booth = acc - {m[WIDTH-1], m};
      default: booth = acc;
    endcase
    dsh   = {acc[WIDTH-1:0], mq[WIDTH-1]};
    ddiff = dsh - {1'b0, m};
    if (op_mul) begin
      {acc_nx, mq_nx, q1_nx} = {booth[WIDTH], booth, mq};
    end else if (!ddiff[WIDTH]) begin
      acc_nx = {1'b0, ddiff[WIDTH-1:0]};
      mq_nx  = {mq[WIDTH-2:0], 1'b1};
      q1_nx  = q1;
    end else begin
      acc_nx = dsh;
      mq_nx  = {mq[WIDTH-2:0], 1'b0};
      q1_nx  = q1;
    end
  end

  // Final mul/div result; divide gets its sign fix-up here.
  always_comb begin
    rf = '0;
    if (op_mul) begin
      rf.lo = mq;
      rf.hi = acc[WIDTH-1:0];
      rf.z  = ({acc[WIDTH-1:0], mq} == '0);
    end else begin
      rf.lo = neg_q ? ('0 - mq) : mq;
      rf.hi = neg_r ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
      rf.z  = (rf.lo == '0);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and handshake outputs; DONE accepts a new op like IDLE.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE, DONE: begin
        done     = (state == DONE);
        state_nx = start ? (iter_op ? RUN : DONE) : IDLE;
      end
      RUN: begin
        busy = 1'b1;
        if (fin) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, iteration and result publication.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      res    <= '0;
      acc    <= '0;
      mq     <= '0;
      q1     <= 1'b0;
      m      <= '0;
      cnt    <= '0;
      fin    <= 1'b0;
      op_mul <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else if (accept) begin
      if (iter_op) begin
        cnt    <= SH'(WIDTH-1);
        fin    <= 1'b0;
        op_mul <= is_mul;
        acc    <= '0;
        q1     <= 1'b0;
        mq     <= is_mul ? B : a_mag;
        m      <= is_mul ? A : b_mag;
        neg_q  <= A[WIDTH-1] ^ B[WIDTH-1];
        neg_r  <= A[WIDTH-1];
      end else begin
        res <= r1;
      end
    end else if (state == RUN) begin
      if (!fin) begin
        // the step taken with cnt == 0 is the last; one more cycle publishes
        acc <= acc_nx;
        mq  <= mq_nx;
        q1  <= q1_nx;
        cnt <= cnt - 1'b1;
        fin <= (cnt == '0);
      end else begin
        res <= rf;
        fin <= 1'b0;
      end
    end
  end

  assign lo      = res.lo;
  assign hi      = res.hi;
  assign zero    = res.z;
  assign carry   = res.c;
  assign div0    = res.d0;
  assign illegal = res.ill;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: WIDTH=32 instance for the main vectors and a
// WIDTH=8 instance for the narrow mul/div corner cases.
module tb_seq_alu;

  localparam logic [4:0] ADD = 5'b00011, SUB = 5'b00100, AND_ = 5'b00101,
                         OR_ = 5'b00110, SHR = 5'b00111, SHRA = 5'b01000,
                         SHL = 5'b01001, ROR = 5'b01010, ROL = 5'b01011,
                         MUL = 5'b01111, DIV = 5'b10000, NEG = 5'b10001,
                         NOT_ = 5'b10010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clear, start;
  logic [4:0]  opcode;
  logic [31:0] A, B, lo, hi;
  logic        busy, done, zero, carry, div0, illegal;

  logic        start8;
  logic [4:0]  op8;
  logic [7:0]  a8, b8, lo8, hi8;
  logic        busy8, done8, zero8, carry8, div08, illegal8;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .clear(clear), .start(start), .opcode(opcode), .A(A), .B(B),
    .lo(lo), .hi(hi), .busy(busy), .done(done), .zero(zero), .carry(carry),
    .div0(div0), .illegal(illegal)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .clear(clear), .start(start8), .opcode(op8), .A(a8), .B(b8),
    .lo(lo8), .hi(hi8), .busy(busy8), .done(done8), .zero(zero8), .carry(carry8),
    .div0(div08), .illegal(illegal8)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Issue one op; edges = rising edges after the accepting edge until done.
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int edges);
    @(negedge clk);
    start = 1'b1; opcode = op; A = a; B = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    while (!done && edges < 100) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic op_chk(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] elo, input logic [31:0] ehi,
                        input int eedges, input logic [3:0] eflg);
    int e;
    do_op(op, a, b, e);
    chk({tag, ".lo"}, lo, elo);
    chk({tag, ".hi"}, hi, ehi);
    chk({tag, ".lat"}, e, eedges);
    chk({tag, ".flg"}, {zero, carry, div0, illegal}, eflg);
  endtask

  initial begin
    int e, cnt;
    clear = 1'b0; start = 1'b0; opcode = '0; A = '0; B = '0;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    #1;
    chk("rst.lo", lo, 0);
    chk("rst.hi", hi, 0);
    chk("rst.ctl", {busy, done, zero, carry, div0, illegal}, 0);
    @(negedge clk); @(negedge clk);
    clear = 1'b1;

    // single-cycle ops; flags are {zero, carry, div0, illegal}
    op_chk("add_wrap", ADD,  32'hFFFFFFFF, 32'h1,        32'h0,        0, 0, 4'b1100);
    op_chk("sub_neg",  SUB,  32'h3,        32'h5,        32'hFFFFFFFE, 0, 0, 4'b0000);
    op_chk("sub_pos",  SUB,  32'h5,        32'h3,        32'h2,        0, 0, 4'b0100);
    op_chk("shra",     SHRA, 32'h80000000, 32'h24,       32'hF8000000, 0, 0, 4'b0000);
    op_chk("ror",      ROR,  32'h1,        32'h1,        32'h80000000, 0, 0, 4'b0000);
    op_chk("rol",      ROL,  32'h80000000, 32'h1,        32'h1,        0, 0, 4'b0000);
    op_chk("shl",      SHL,  32'h1,        32'h1F,       32'h80000000, 0, 0, 4'b0000);
    op_chk("shl_amt0", SHL,  32'h12345678, 32'h20,       32'h12345678, 0, 0, 4'b0000);
    op_chk("shr",      SHR,  32'h80000000, 32'h1F,       32'h1,        0, 0, 4'b0000);
    op_chk("and",      AND_, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 4'b0000);
    op_chk("or",       OR_,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0, 0, 4'b0000);
    op_chk("neg",      NEG,  32'h1,        32'h0,        32'hFFFFFFFF, 0, 0, 4'b0000);
    op_chk("neg0",     NEG,  32'h0,        32'h0,        32'h0,        0, 0, 4'b1000);
    op_chk("not",      NOT_, 32'h0,        32'h0,        32'hFFFFFFFF, 0, 0, 4'b0000);

    // multiply
    op_chk("mul_m3x7", MUL, 32'hFFFFFFFD, 32'h7,        32'hFFFFFFEB, 32'hFFFFFFFF, 33, 4'b0000);
    op_chk("mul_min2", MUL, 32'h80000000, 32'h80000000, 32'h0,        32'h40000000, 33, 4'b0000);
    op_chk("mul_max2", MUL, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h1,        32'h3FFFFFFF, 33, 4'b0000);
    op_chk("mul_zero", MUL, 32'h0,        32'h3039,     32'h0,        32'h0,        33, 4'b1000);

    // divide
    op_chk("div_m7d2", DIV, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 32'hFFFFFFFF, 33, 4'b0000);
    op_chk("div_100d7",DIV, 32'h64,       32'h7,        32'hE,        32'h2,        33, 4'b0000);
    op_chk("div_7dm2", DIV, 32'h7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h1,        33, 4'b0000);
    op_chk("div_ovf",  DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0,        33, 4'b0000);
    op_chk("div_by0",  DIV, 32'h7,        32'h0,        32'hFFFFFFFF, 32'h7,        0,  4'b0010);

    // illegal opcodes
    op_chk("ill_1f",   5'b11111, 32'h5, 32'h6, 32'h0, 32'h0, 0, 4'b1001);
    op_chk("ill_00",   5'b00000, 32'h5, 32'h6, 32'h0, 32'h0, 0, 4'b1001);

    // start during RUN is ignored
    @(negedge clk);
    start = 1'b1; opcode = MUL; A = 32'd6; B = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("hs.busy", busy, 1'b1);
    e = 0;
    while (!done && e < 100) begin
      if (e == 4) begin start = 1'b1; opcode = ADD; A = 32'd1; B = 32'd1; end
      else start = 1'b0;
      @(negedge clk);
      e++;
    end
    start = 1'b0;
    chk("hs.lat", e, 33);
    chk("hs.lo", lo, 32'd42);
    chk("hs.hi", hi, 32'd0);
    @(negedge clk);
    chk("hs.pulse", done, 1'b0);

    // start held: div accepted straight out of the mul's DONE cycle
    @(negedge clk);
    start = 1'b1; opcode = MUL; A = 32'd2; B = 32'd3;
    @(posedge clk);
    @(negedge clk);
    e = 0;
    while (!done && e < 100) begin
      @(negedge clk);
      e++;
    end
    chk("b2b.mul_lat", e, 33);
    chk("b2b.mul_lo", lo, 32'd6);
    opcode = DIV; A = 32'd100; B = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("b2b.gap", {busy, done}, 2'b10);
    e = 0;
    while (!done && e < 100) begin
      @(negedge clk);
      e++;
    end
    chk("b2b.div_lat", e, 33);
    chk("b2b.div_lo", lo, 32'd14);
    chk("b2b.div_hi", hi, 32'd2);

    // asynchronous reset in the middle of a multiply
    @(negedge clk);
    start = 1'b1; opcode = MUL; A = 32'hFFFFFFFD; B = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 clear = 1'b0;
    #1;
    chk("rmid.lo", lo, 0);
    chk("rmid.hi", hi, 0);
    chk("rmid.ctl", {busy, done, zero, carry, div0, illegal}, 0);
    @(negedge clk);
    clear = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("rmid.nodone", cnt, 0);
    chk("rmid.idle", busy, 1'b0);
    op_chk("rmid.add", ADD, 32'd5, 32'd7, 32'd12, 32'd0, 0, 4'b0000);

    // WIDTH=8 instance
    @(negedge clk);
    start8 = 1'b1; op8 = MUL; a8 = 8'h80; b8 = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    e = 0;
    while (!done8 && e < 100) begin
      @(negedge clk);
      e++;
    end
    chk("w8.mul_lat", e, 9);
    chk("w8.mul_lo", lo8, 8'h80);
    chk("w8.mul_hi", hi8, 8'h00);

    @(negedge clk);
    start8 = 1'b1; op8 = DIV; a8 = 8'h80; b8 = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    e = 0;
    while (!done8 && e < 100) begin
      @(negedge clk);
      e++;
    end
    chk("w8.div_lat", e, 9);
    chk("w8.div_lo", lo8, 8'h80);
    chk("w8.div_hi", hi8, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
